// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port AXI controller among NPORT requesters (I-cache,
// D-cache, MMIO). A round-robin search picks the winner, whose command is
// latched and issued downstream as a one-cycle request. While the controller
// is busy, the refill-FIFO index, data and done handshake are steered between
// the granted requester and the controller. Every transaction ends with a
// RELEASE cycle, so there is always an idle cycle before the next grant. A
// requester can keep the controller across transactions (for example a
// writeback followed by a refill) by holding lock_i.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_i           per-port request level, held until done
//   rw_i            per-port direction (0 read, 1 write)
//   addr_i          per-port address, port p at [p*ADDR_W +: ADDR_W]
//   wdata_i         per-port write data, port p at [p*DATA_W +: DATA_W]
//   len_i           per-port burst length, port p at [p*LEN_W +: LEN_W]
//   lock_i          per-port "keep the grant after this transaction"
//   fifo_idx_i      per-port refill-FIFO bit index, port p at [p*IDX_W +: IDX_W]
//   fifo_done_i     per-port "FIFO consumed"
//   gnt_o           one-hot grant, held from ISSUE through RELEASE
//   done_o          per-port done, only the granted bit can be set
//   rdata_o         controller FIFO data, broadcast to all ports
//   dn_ready_i      controller idle and able to accept a request
//   dn_req_o        one-cycle request pulse to the controller
//   dn_rw_o, dn_addr_o, dn_wdata_o, dn_len_o   latched command
//   dn_rdata_i      controller FIFO data
//   dn_done_i       controller transaction done (level)
//   dn_fifo_idx_o   FIFO index forwarded from the granted port
//   dn_fifo_done_o  FIFO-consumed forwarded from the granted port
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int NPORT  = 3,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8,
    parameter int IDX_W  = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NPORT-1:0]        req_i,
    input  logic [NPORT-1:0]        rw_i,
    input  logic [NPORT*ADDR_W-1:0] addr_i,
    input  logic [NPORT*DATA_W-1:0] wdata_i,
    input  logic [NPORT*LEN_W-1:0]  len_i,
    input  logic [NPORT-1:0]        lock_i,
    input  logic [NPORT*IDX_W-1:0]  fifo_idx_i,
    input  logic [NPORT-1:0]        fifo_done_i,
    output logic [NPORT-1:0]        gnt_o,
    output logic [NPORT-1:0]        done_o,
    output logic [DATA_W-1:0]       rdata_o,
    input  logic                    dn_ready_i,
    output logic                    dn_req_o,
    output logic                    dn_rw_o,
    output logic [ADDR_W-1:0]       dn_addr_o,
    output logic [DATA_W-1:0]       dn_wdata_o,
    output logic [LEN_W-1:0]        dn_len_o,
    input  logic [DATA_W-1:0]       dn_rdata_i,
    input  logic                    dn_done_i,
    output logic [IDX_W-1:0]        dn_fifo_idx_o,
    output logic                    dn_fifo_done_o
);

    localparam int PTR_W = (NPORT > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   own_q, own_d;
    logic               lock_hold_q, lock_hold_d;
    logic [NPORT-1:0]   gnt_q, gnt_d;
    logic               dn_req_q, dn_req_d;
    logic               dn_rw_q, dn_rw_d;
    logic [ADDR_W-1:0]  dn_addr_q, dn_addr_d;
    logic [DATA_W-1:0]  dn_wdata_q, dn_wdata_d;
    logic [LEN_W-1:0]   dn_len_q, dn_len_d;

    logic [NPORT-1:0]   own_mask;
    logic               lock_own;
    logic [NPORT-1:0]   eligible;
    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;
    logic [NPORT-1:0]   win_mask;
    logic [PTR_W-1:0]   own_next;
    int                 cand;
    logic               in_busy;
    logic               fifo_done_fwd;

    // -------------------------------------------------------------------------
    // Arbitration: owner decode, lock filtering and cyclic search from ptr.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            own_mask[p] = (int'(own_q) == p);
        end
        lock_own = |(lock_i & own_mask);

        // A held lock only narrows the field while the owner keeps lock_i up;
        // once it drops, everyone competes again in the same cycle.
        eligible = req_i;
        if (lock_hold_q && lock_own) begin
            eligible = req_i & own_mask;
        end

        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 0; i < NPORT; i++) begin
            cand = (int'(ptr_q) + i) % NPORT;
            if (!win_vld && eligible[cand]) begin
                win_vld = 1'b1;
                win_idx = cand[PTR_W-1:0];
            end
        end

        for (int p = 0; p < NPORT; p++) begin
            win_mask[p] = win_vld && (int'(win_idx) == p);
        end

        own_next = (int'(own_q) == NPORT - 1) ? '0 : own_q + 1'b1;
    end

    // -------------------------------------------------------------------------
    // Downstream handshake steering (combinational in BUSY only).
    // -------------------------------------------------------------------------
    always_comb begin
        in_busy       = (state_q == S_BUSY);
        fifo_done_fwd = in_busy && dn_done_i && |(fifo_done_i & own_mask);

        done_o         = (in_busy && dn_done_i) ? own_mask : '0;
        dn_fifo_done_o = fifo_done_fwd;
        dn_fifo_idx_o  = '0;
        if (in_busy) begin
            dn_fifo_idx_o = fifo_idx_i[int'(own_q)*IDX_W +: IDX_W];
        end
        rdata_o = dn_rdata_i;
    end

    // -------------------------------------------------------------------------
    // FSM next-state and registered outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        own_d       = own_q;
        lock_hold_d = lock_hold_q;
        gnt_d       = gnt_q;
        dn_req_d    = 1'b0;
        dn_rw_d     = dn_rw_q;
        dn_addr_d   = dn_addr_q;
        dn_wdata_d  = dn_wdata_q;
        dn_len_d    = dn_len_q;

        unique case (state_q)
            S_IDLE: begin
                gnt_d       = '0;
                lock_hold_d = lock_hold_q && lock_own;
                if (dn_ready_i && win_vld) begin
                    own_d      = win_idx;
                    gnt_d      = win_mask;
                    dn_req_d   = 1'b1;
                    dn_rw_d    = rw_i[win_idx];
                    dn_addr_d  = addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
                    dn_wdata_d = wdata_i[int'(win_idx)*DATA_W +: DATA_W];
                    dn_len_d   = len_i[int'(win_idx)*LEN_W +: LEN_W];
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (fifo_done_fwd) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // A locking owner keeps ptr so it does not lose its turn
                // position once the chained sequence finishes.
                lock_hold_d = lock_own;
                ptr_d       = lock_own ? ptr_q : own_next;
                gnt_d       = '0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            own_q       <= '0;
            lock_hold_q <= 1'b0;
            gnt_q       <= '0;
            dn_req_q    <= 1'b0;
            dn_rw_q     <= 1'b0;
            dn_addr_q   <= '0;
            dn_wdata_q  <= '0;
            dn_len_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            own_q       <= own_d;
            lock_hold_q <= lock_hold_d;
            gnt_q       <= gnt_d;
            dn_req_q    <= dn_req_d;
            dn_rw_q     <= dn_rw_d;
            dn_addr_q   <= dn_addr_d;
            dn_wdata_q  <= dn_wdata_d;
            dn_len_q    <= dn_len_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign dn_req_o   = dn_req_q;
    assign dn_rw_o    = dn_rw_q;
    assign dn_addr_o  = dn_addr_q;
    assign dn_wdata_o = dn_wdata_q;
    assign dn_len_o   = dn_len_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Each expected downstream command is
// pushed to a scoreboard queue as its requester is driven; a negedge monitor
// pops and compares on every dn_req_o pulse. Directed checks cover reset,
// handshake steering, lock chaining, back-pressure, isolation and async reset.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int NPORT  = 3;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 8;
    localparam int IDX_W  = 9;

    logic                    clk;
    logic                    rst_n;
    logic [NPORT-1:0]        req_i;
    logic [NPORT-1:0]        rw_i;
    logic [NPORT*ADDR_W-1:0] addr_i;
    logic [NPORT*DATA_W-1:0] wdata_i;
    logic [NPORT*LEN_W-1:0]  len_i;
    logic [NPORT-1:0]        lock_i;
    logic [NPORT*IDX_W-1:0]  fifo_idx_i;
    logic [NPORT-1:0]        fifo_done_i;
    logic [NPORT-1:0]        gnt_o;
    logic [NPORT-1:0]        done_o;
    logic [DATA_W-1:0]       rdata_o;
    logic                    dn_ready_i;
    logic                    dn_req_o;
    logic                    dn_rw_o;
    logic [ADDR_W-1:0]       dn_addr_o;
    logic [DATA_W-1:0]       dn_wdata_o;
    logic [LEN_W-1:0]        dn_len_o;
    logic [DATA_W-1:0]       dn_rdata_i;
    logic                    dn_done_i;
    logic [IDX_W-1:0]        dn_fifo_idx_o;
    logic                    dn_fifo_done_o;

    mem_port_arbiter #(
        .NPORT (NPORT),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .rw_i          (rw_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .len_i         (len_i),
        .lock_i        (lock_i),
        .fifo_idx_i    (fifo_idx_i),
        .fifo_done_i   (fifo_done_i),
        .gnt_o         (gnt_o),
        .done_o        (done_o),
        .rdata_o       (rdata_o),
        .dn_ready_i    (dn_ready_i),
        .dn_req_o      (dn_req_o),
        .dn_rw_o       (dn_rw_o),
        .dn_addr_o     (dn_addr_o),
        .dn_wdata_o    (dn_wdata_o),
        .dn_len_o      (dn_len_o),
        .dn_rdata_i    (dn_rdata_i),
        .dn_done_i     (dn_done_i),
        .dn_fifo_idx_o (dn_fifo_idx_o),
        .dn_fifo_done_o(dn_fifo_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NPORT-1:0]  gnt;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [LEN_W-1:0]  len;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input logic rw, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd, input logic [LEN_W-1:0] ln,
                            input logic [IDX_W-1:0] ix);
        rw_i[p]                        = rw;
        addr_i[p*ADDR_W +: ADDR_W]     = a;
        wdata_i[p*DATA_W +: DATA_W]    = wd;
        len_i[p*LEN_W +: LEN_W]        = ln;
        fifo_idx_i[p*IDX_W +: IDX_W]   = ix;
    endtask

    // Expected command is the port's command as driven right now.
    task automatic expect_txn(input int p);
        exp_t e;
        e.gnt    = '0;
        e.gnt[p] = 1'b1;
        e.rw     = rw_i[p];
        e.addr   = addr_i[p*ADDR_W +: ADDR_W];
        e.wdata  = wdata_i[p*DATA_W +: DATA_W];
        e.len    = len_i[p*LEN_W +: LEN_W];
        sb.push_back(e);
    endtask

    // Scoreboard monitor: one pop per downstream request pulse.
    always @(negedge clk) begin
        if (rst_n && dn_req_o) begin
            if (sb.size() == 0) begin
                check_val("sb_unexpected_req", 64'(dn_req_o), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check_val("sb_gnt",   64'(gnt_o),      64'(mon_e.gnt));
                check_val("sb_rw",    64'(dn_rw_o),    64'(mon_e.rw));
                check_val("sb_addr",  dn_addr_o,       mon_e.addr);
                check_val("sb_wdata", dn_wdata_o,      mon_e.wdata);
                check_val("sb_len",   64'(dn_len_o),   64'(mon_e.len));
            end
        end
    end

    // Waits (bounded) for the request pulse; returns grant seen and cycles waited.
    task automatic wait_req(input int bound, output logic [NPORT-1:0] g, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!dn_req_o && waited < bound);
        check_val("req_seen", 64'(dn_req_o), 64'd1);
        g = gnt_o;
    endtask

    // Runs BUSY for 'busy' cycles then completes the handshake and RELEASE.
    task automatic end_txn(input logic [NPORT-1:0] g, input int busy,
                           input logic [NPORT-1:0] drop, input logic [IDX_W-1:0] exp_idx);
        @(negedge clk);
        check_val("req_one_cycle", 64'(dn_req_o), 64'd0);
        check_val("fifo_idx_fwd",  64'(dn_fifo_idx_o), 64'(exp_idx));
        repeat (busy - 1) @(negedge clk);
        dn_done_i   = 1'b1;
        fifo_done_i = g;
        req_i       = req_i & ~drop;
        #1;
        check_val("done_follow",   64'(done_o), 64'(g));
        check_val("fifo_done_fwd", 64'(dn_fifo_done_o), 64'd1);
        @(negedge clk);
        check_val("release_done",  64'(done_o), 64'd0);
        check_val("release_fdone", 64'(dn_fifo_done_o), 64'd0);
        check_val("release_gnt",   64'(gnt_o), 64'(g));
        dn_done_i   = 1'b0;
        fifo_done_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NPORT-1:0] g;
        int               w;

        rst_n       = 1'b0;
        req_i       = '0;
        rw_i        = '0;
        addr_i      = '0;
        wdata_i     = '0;
        len_i       = '0;
        lock_i      = '0;
        fifo_idx_i  = '0;
        fifo_done_i = '0;
        dn_ready_i  = 1'b0;
        dn_rdata_i  = '0;
        dn_done_i   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_gnt",    64'(gnt_o), 64'd0);
        check_val("rst_done",   64'(done_o), 64'd0);
        check_val("rst_req",    64'(dn_req_o), 64'd0);
        check_val("rst_fdone",  64'(dn_fifo_done_o), 64'd0);
        check_val("rst_rw",     64'(dn_rw_o), 64'd0);
        check_val("rst_addr",   dn_addr_o, 64'd0);
        check_val("rst_wdata",  dn_wdata_o, 64'd0);
        check_val("rst_len",    64'(dn_len_o), 64'd0);
        check_val("rst_idx",    64'(dn_fifo_idx_o), 64'd0);
        dn_rdata_i = 64'hDEAD_BEEF_0123_4567;
        #1;
        check_val("rdata_pass", rdata_o, 64'hDEAD_BEEF_0123_4567);
        rst_n = 1'b1;

        // Single read on port 1
        @(negedge clk);
        set_port(1, 1'b0, 64'h8000_0040, 64'h0, 8'd7, 9'h015);
        dn_ready_i = 1'b1;
        req_i[1]   = 1'b1;
        expect_txn(1);
        wait_req(20, g, w);
        check_val("t1_latency", 64'(w), 64'd1);
        check_val("t1_gnt", 64'(g), 64'b010);
        end_txn(g, 2, 3'b010, 9'h015);
        @(negedge clk);
        check_val("t1_idle_gnt", 64'(gnt_o), 64'd0);

        // Fairness from ptr = 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < NPORT; p++) begin
            set_port(p, p[0], 64'h1000 + 64'(p) * 64'h100, 64'hA0 + 64'(p), 8'(p + 1), 9'(p + 10));
        end
        req_i = 3'b111;
        for (int k = 0; k < 6; k++) expect_txn(k % 3);
        for (int k = 0; k < 6; k++) begin
            logic [NPORT-1:0] m;
            m        = '0;
            m[k % 3] = 1'b1;
            wait_req(20, g, w);
            check_val("fair_gnt", 64'(g), 64'(m));
            end_txn(g, 1 + (k % 2), (k == 5) ? 3'b111 : 3'b000, 9'((k % 3) + 10));
        end

        // Lock chaining on port 1 (ptr is 0 here)
        set_port(1, 1'b1, 64'h2000_0100, 64'h1111_2222, 8'd3, 9'h031);
        lock_i = 3'b010;
        req_i  = 3'b010;
        expect_txn(1);
        wait_req(20, g, w);
        check_val("lock_gnt1", 64'(g), 64'b010);
        set_port(1, 1'b0, 64'h2000_0200, 64'h0, 8'd5, 9'h032);
        set_port(0, 1'b0, 64'h3000_0000, 64'h0, 8'd1, 9'h040);
        set_port(2, 1'b0, 64'h5000_0000, 64'h0, 8'd2, 9'h050);
        req_i = 3'b111;
        expect_txn(1);
        expect_txn(2);
        #1;
        check_val("lock_addr_latched", dn_addr_o, 64'h2000_0100);
        end_txn(g, 2, 3'b000, 9'h032);
        wait_req(20, g, w);
        check_val("lock_gnt2", 64'(g), 64'b010);
        lock_i = 3'b000;
        end_txn(g, 1, 3'b010, 9'h032);
        wait_req(20, g, w);
        check_val("lock_gnt3", 64'(g), 64'b100);
        end_txn(g, 1, 3'b101, 9'h050);

        // Back-pressure, then isolation while port 0 is busy
        @(negedge clk);
        dn_ready_i = 1'b0;
        set_port(0, 1'b0, 64'h7000_0080, 64'h0, 8'd4, 9'h0AA);
        req_i = 3'b001;
        expect_txn(0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_val("bp_no_gnt", 64'(gnt_o), 64'd0);
            check_val("bp_no_req", 64'(dn_req_o), 64'd0);
        end
        dn_ready_i = 1'b1;
        wait_req(20, g, w);
        check_val("bp_latency", 64'(w), 64'd1);
        @(negedge clk);
        dn_done_i   = 1'b1;
        req_i       = 3'b100;
        fifo_done_i = 3'b100;
        set_port(2, 1'b1, 64'h9999_0000, 64'h5555, 8'd9, 9'h1FF);
        dn_rdata_i  = 64'h0F0F_F0F0_1234_5678;
        #1;
        check_val("iso_done",   64'(done_o), 64'b001);
        check_val("iso_fdone",  64'(dn_fifo_done_o), 64'd0);
        check_val("iso_addr",   dn_addr_o, 64'h7000_0080);
        check_val("iso_idx",    64'(dn_fifo_idx_o), 64'h0AA);
        check_val("iso_rdata",  rdata_o, 64'h0F0F_F0F0_1234_5678);
        fifo_done_i = 3'b000;
        req_i       = 3'b000;
        #1;
        check_val("iso_fdone_low", 64'(dn_fifo_done_o), 64'd0);
        fifo_done_i = 3'b001;
        #1;
        check_val("iso_fdone_own", 64'(dn_fifo_done_o), 64'd1);
        @(negedge clk);
        dn_done_i   = 1'b0;
        fifo_done_i = '0;
        @(negedge clk);
        check_val("iso_idle_gnt", 64'(gnt_o), 64'd0);

        // Async reset in the middle of BUSY
        set_port(1, 1'b1, 64'hABCD_0000, 64'h77, 8'd6, 9'h011);
        req_i = 3'b010;
        expect_txn(1);
        wait_req(20, g, w);
        @(negedge clk);
        dn_done_i = 1'b1;
        #1;
        check_val("ar_done_before", 64'(done_o), 64'b010);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("ar_gnt",   64'(gnt_o), 64'd0);
        check_val("ar_done",  64'(done_o), 64'd0);
        check_val("ar_req",   64'(dn_req_o), 64'd0);
        check_val("ar_addr",  dn_addr_o, 64'd0);
        check_val("ar_len",   64'(dn_len_o), 64'd0);
        dn_done_i = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            set_port(p, 1'b0, 64'hC000 + 64'(p), 64'h0, 8'(p + 2), 9'(p + 20));
        end
        req_i = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;
        expect_txn(0);
        wait_req(20, g, w);
        check_val("ar_first_gnt", 64'(g), 64'b001);
        end_txn(g, 1, 3'b111, 9'd20);

        repeat (3) @(negedge clk);
        check_val("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
